mem_refill_arbiter: RTL and testbench
=====================================

Name: mem_refill_arbiter

Overview:
- Shares the single external memory read port between the cache refill engines: port 0 is the icache and port 1 is the dcache, extendable via NUM_REQ.
- Each granted request is one full-line refill: one address phase, then WORDS_PER_LINE data beats returned to the owner.
- Round-robin fairness between requesters; one line transaction in flight at a time.
- Sits between the per-cache MISS/REFILL FSMs and the memory model/bus.

Parameters:
NUM_REQ, 2, number of requesters (index 0 = icache, 1 = dcache)
ADDR_WIDTH, 32, byte address width
WORD_WIDTH, 32, data beat width
LINE_WIDTH, 128, cache line width; WORDS_PER_LINE = LINE_WIDTH/WORD_WIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  NUM_REQ  per-requester line-refill request, level, held until granted
req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester miss address, slice r at [r*ADDR_WIDTH +: ADDR_WIDTH]
gnt_o  out  NUM_REQ  one-hot grant, one-cycle pulse when the request is captured
rsp_valid_o  out  NUM_REQ  one-hot, data beat valid for the owning requester
rsp_data_o  out  WORD_WIDTH  shared beat data
rsp_last_o  out  1  final beat of the line
mem_req_o  out  1  memory read request
mem_addr_o  out  ADDR_WIDTH  line-aligned address
mem_ready_i  in  1  memory accepts the request
mem_valid_i  in  1  memory data beat valid
mem_data_i  in  WORD_WIDTH  memory data beat
err_o  out  1  sticky protocol error flag

Behaviour:
- The clock and reset are fixed: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, addr_q=0.
  - All outputs 0.
- States:
  - IDLE:
    - If any req_i is set, pick the winner: the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
    - gnt_o[winner]=1 combinationally in the same cycle.
    - Latch owner=winner and addr_q = req_addr_i[winner] with the low log2(LINE_WIDTH/8) bits cleared.
    - Go to ISSUE.
  - ISSUE:
    - mem_req_o=1 and mem_addr_o=addr_q.
    - Stay until mem_ready_i=1 is sampled, then go to BEAT with beat_cnt=0.
    - mem_addr_o is stable while mem_req_o is high.
  - BEAT:
    - Each cycle with mem_valid_i=1: rsp_valid_o[owner]=1 and rsp_data_o=mem_data_i, same cycle (zero latency), then beat_cnt++.
    - On the beat where beat_cnt==WORDS_PER_LINE-1:
      - rsp_last_o=1.
      - rr_ptr <= (owner+1) mod NUM_REQ.
      - beat_cnt <= 0 and go to IDLE.
    - Gaps (mem_valid_i=0) are allowed with no timeout.
- Latency:
  - req_i rising in IDLE gives gnt_o in cycle 0 and mem_req_o in cycle 1.
  - The earliest first beat is cycle 2.
  - Minimum line turnaround is WORDS_PER_LINE+2 cycles; the next grant is issued in the IDLE cycle after the last beat.
- Fairness:
  - The requester just served has lowest priority next.
  - With both requesting continuously, grants alternate 0,1,0,1.
- Requests:
  - req_i of non-owners is ignored while not IDLE.
  - The owner must deassert req_i in or after its gnt_o cycle.
  - req_i still high in the IDLE cycle after rsp_last_o is a new request.
- Outside the burst:
  - When not BEAT: rsp_data_o=0 and rsp_valid_o=0.
  - mem_valid_i in IDLE/ISSUE is dropped and sets err_o.
  - err_o clears only on reset.
- beat_cnt width: $clog2(WORDS_PER_LINE), minimum 1; it wraps to 0 only via the last-beat transition.
- Reset mid-burst:
  - Immediately returns to IDLE and aborts the burst.
  - No rsp_last_o is produced; remaining beats after release are ignored and flagged per the rule above.
- gnt_o, rsp_valid_o and rsp_last_o are never asserted to a requester other than owner/winner and are never multi-hot.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, BEAT}, logic [1:0].
  - Helper localparams WORDS_PER_LINE, LINE_OFFSET_BITS, BEAT_CNT_BITS as functions of the parameters.
- One sub-module rr_arbiter (parameter N): combinational; inputs req vector and rr_ptr; outputs one-hot gnt and winner index plus any_req.
- The FSM, counters and data routing stay in mem_refill_arbiter.

Test Plan:
1. Icache only: req_i=01, addr 0x0000_1234 -> gnt_o=01 at c0; mem_req_o with mem_addr_o=0x0000_1230 at c1; mem_ready_i at c1; beats 0xA0..0xA3 at c2..c5 -> rsp_valid_o=01 with matching data; rsp_last_o at c5; back to IDLE at c6.
2. Simultaneous req_i=11 held continuously after reset -> grants in order 01,10,01; each line gets exactly 4 beats routed to the correct port only.
3. mem_ready_i held 0 for 5 cycles in ISSUE -> mem_req_o stays 1 with constant mem_addr_o; BEAT is entered only after mem_ready_i=1.
4. Beats with gaps (valid pattern 1,0,0,1,1,0,1) -> exactly 4 rsp_valid_o pulses; rsp_last_o on the 4th only.
5. Reset asserted after the 2nd beat -> all outputs 0 in the same cycle; rr_ptr=0; the following request from port 1 alone is granted normally.
6. mem_valid_i=1 while IDLE -> no rsp_valid_o; err_o=1 and remains set until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and size helpers for the memory refill arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BEAT} arb_state_t;

  function automatic int words_per_line(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  function automatic int line_offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int beat_cnt_bits(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

  localparam int WORDS_PER_LINE   = words_per_line(128, 32);
  localparam int LINE_OFFSET_BITS = line_offset_bits(128);
  localparam int BEAT_CNT_BITS    = beat_cnt_bits(WORDS_PER_LINE);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int c;

  // Walk from the farthest candidate back toward ptr so the nearest hit wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    c       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % N;
      if (req[c[IW-1:0]]) begin
        idx     = c[IW-1:0];
        any_req = 1'b1;
      end
    end
    if (any_req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one memory read port between cache refill engines, one full line
// per grant, round-robin between requesters.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int WORD_WIDTH = 32,
  parameter  int LINE_WIDTH = 128,
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WORD_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_last_o,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_valid_i,
  input  logic [WORD_WIDTH-1:0]         mem_data_i,
  output logic                          err_o
);

  localparam int WPL = words_per_line(LINE_WIDTH, WORD_WIDTH);
  localparam int LOB = line_offset_bits(LINE_WIDTH);
  localparam int BCW = beat_cnt_bits(WPL);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LOB;

  arb_state_t                           state, state_nxt;
  logic [IW-1:0]                        rr_ptr, owner, arb_idx;
  logic [BCW-1:0]                       beat_cnt;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic                                 err_q;
  logic [NUM_REQ-1:0]                   arb_gnt;
  logic                                 arb_any, beat_fire, last_beat;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_a;

  assign req_addr_a = req_addr_i;
  assign err_o      = err_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant is masked while reset is held so no output leaks during reset.
  always_comb begin
    state_nxt   = state;
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_last_o  = 1'b0;
    beat_fire   = 1'b0;
    last_beat   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any && !reset) begin
          gnt_o     = arb_gnt;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ready_i) state_nxt = BEAT;
      end
      BEAT: begin
        if (mem_valid_i) begin
          beat_fire          = 1'b1;
          rsp_valid_o[owner] = 1'b1;
          rsp_data_o         = mem_data_i;
          if (beat_cnt == BCW'(WPL - 1)) begin
            last_beat  = 1'b1;
            rsp_last_o = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && arb_any) begin
        owner  <= arb_idx;
        addr_q <= req_addr_a[arb_idx] & LINE_MASK;
      end
      if (state == ISSUE && mem_ready_i) beat_cnt <= '0;
      else if (beat_fire)                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      // Just-served requester drops to lowest priority.
      if (last_beat) rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      if (mem_valid_i && state != BEAT) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed scoreboard bench for mem_refill_arbiter.
module tb_mem_refill_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i;
  logic [63:0] req_addr_i;
  logic [1:0]  gnt_o, rsp_valid_o;
  logic [31:0] rsp_data_o, mem_addr_o, mem_data_i;
  logic        rsp_last_o, mem_req_o, mem_ready_i, mem_valid_i, err_o;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
    logic        l;
  } rsp_t;

  logic [1:0]  gq[$];
  logic [31:0] aq[$];
  rsp_t        rq[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mem_refill_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_last_o  (rsp_last_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .err_o       (err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT-presented grant / address handshake / beat pops the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (gnt_o != 2'b00) begin
      if (gq.size() == 0) chk("gnt_unexpected", {30'd0, gnt_o}, 32'd0);
      else                chk("gnt_order", {30'd0, gnt_o}, {30'd0, gq.pop_front()});
    end
    if (mem_req_o && mem_ready_i) begin
      if (aq.size() == 0) chk("addr_unexpected", {31'd0, mem_req_o}, 32'd0);
      else                chk("mem_addr", mem_addr_o, aq.pop_front());
    end
    if (rsp_valid_o != 2'b00) begin
      if (rq.size() == 0) chk("rsp_unexpected", {30'd0, rsp_valid_o}, 32'd0);
      else begin
        e = rq.pop_front();
        chk("rsp_port", {30'd0, rsp_valid_o}, {30'd0, e.v});
        chk("rsp_data", rsp_data_o, e.d);
        chk("rsp_last", {31'd0, rsp_last_o}, {31'd0, e.l});
      end
    end
  end

  // One refill from the grant cycle: rw extra ISSUE wait cycles, vp gap pattern
  // (LSB first), nb beats delivered, drop = request bits released after grant.
  task automatic do_line(input logic [1:0] eg, input logic [31:0] ea, input logic [31:0] db,
                         input int rw, input logic [15:0] vp, input logic [1:0] drop, input int nb);
    int   nv;
    logic b;
    gq.push_back(eg);
    aq.push_back(ea);
    for (int k = 0; k < nb; k++) rq.push_back('{v: eg, d: db + k, l: (k == 3)});
    tick;
    req_i       = req_i & ~drop;
    mem_ready_i = (rw == 0);
    @(negedge clk);
    chk("issue_req", {31'd0, mem_req_o}, 32'd1);
    chk("issue_addr", mem_addr_o, ea);
    for (int w = 0; w < rw; w++) begin
      tick;
      mem_ready_i = (w == rw - 1);
      @(negedge clk);
      chk("hold_req", {31'd0, mem_req_o}, 32'd1);
      chk("hold_addr", mem_addr_o, ea);
    end
    tick;
    mem_ready_i = 1'b0;
    nv = 0;
    for (int k = 0; k < 32 && nv < nb; k++) begin
      b           = (k < 16) ? vp[k[3:0]] : 1'b1;
      mem_valid_i = b;
      mem_data_i  = b ? db + nv : 32'hDEAD_BEEF;
      @(negedge clk);
      if (!b) begin
        chk("gap_valid", {30'd0, rsp_valid_o}, 32'd0);
        chk("gap_data", rsp_data_o, 32'd0);
      end
      if (b) nv++;
      tick;
    end
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
  endtask

  initial begin
    reset = 1'b1; req_i = 2'b11; req_addr_i = '0;
    mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    tick; tick;
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_rsp_last", {31'd0, rsp_last_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    tick;
    req_i = 2'b00; reset = 1'b0;
    tick;

    // 1: icache alone, back-to-back beats
    req_addr_i = {32'h0, 32'h0000_1234};
    req_i = 2'b01;
    do_line(2'b01, 32'h0000_1230, 32'hA0, 0, 16'hFFFF, 2'b01, 4);
    @(negedge clk);
    chk("idle_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("idle_last", {31'd0, rsp_last_o}, 32'd0);
    tick;

    // 2: both held across reset release -> 01,10,01
    reset = 1'b1; req_i = 2'b11;
    req_addr_i = {32'h8000_00FF, 32'h0000_2008};
    tick; tick;
    reset = 1'b0;
    do_line(2'b01, 32'h0000_2000, 32'hB0, 0, 16'hFFFF, 2'b00, 4);
    do_line(2'b10, 32'h8000_00F0, 32'hC0, 0, 16'hFFFF, 2'b00, 4);
    do_line(2'b01, 32'h0000_2000, 32'hD0, 0, 16'hFFFF, 2'b11, 4);
    tick;

    // 3: dcache, memory stalls ISSUE for 5 cycles
    req_addr_i = {32'h0000_3FFC, 32'h0};
    req_i = 2'b10;
    do_line(2'b10, 32'h0000_3FF0, 32'hE0, 5, 16'hFFFF, 2'b10, 4);
    tick;

    // 4: icache, beats with gaps 1,0,0,1,1,0,1
    req_addr_i = {32'h0, 32'h0000_401F};
    req_i = 2'b01;
    do_line(2'b01, 32'h0000_4010, 32'hF0, 0, 16'h0059, 2'b01, 4);
    tick;

    // 5: icache line aborted by reset after two beats (rr_ptr is 1 here)
    req_addr_i = {32'h0, 32'h0000_5000};
    req_i = 2'b01;
    do_line(2'b01, 32'h0000_5000, 32'h10, 0, 16'hFFFF, 2'b01, 2);
    reset = 1'b1; mem_valid_i = 1'b1; mem_data_i = 32'h77;
    @(negedge clk);
    chk("abort_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("abort_rsp_data", rsp_data_o, 32'd0);
    chk("abort_last", {31'd0, rsp_last_o}, 32'd0);
    chk("abort_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("abort_err", {31'd0, err_o}, 32'd0);
    tick;
    reset = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    req_addr_i = {32'h6000_0004, 32'h7000_0008};
    req_i = 2'b11;
    do_line(2'b01, 32'h7000_0000, 32'h20, 0, 16'hFFFF, 2'b01, 4);
    do_line(2'b10, 32'h6000_0000, 32'h30, 0, 16'hFFFF, 2'b10, 4);
    tick;

    // 6: stray beat while IDLE
    req_i = 2'b00; mem_valid_i = 1'b1; mem_data_i = 32'h55;
    @(negedge clk);
    chk("stray_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("stray_data", rsp_data_o, 32'd0);
    chk("err_pre", {31'd0, err_o}, 32'd0);
    tick;
    mem_valid_i = 1'b0; mem_data_i = '0;
    @(negedge clk);
    chk("err_set", {31'd0, err_o}, 32'd1);
    tick; tick; tick;
    @(negedge clk);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    tick;
    reset = 1'b0;
    tick;

    chk("gnt_left", gq.size(), 32'd0);
    chk("addr_left", aq.size(), 32'd0);
    chk("rsp_left", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
